// File: rtl/phy_mdio_pkg.sv
// phy_mdio_pkg: shared field constants, widths and FSM state type for the MDIO responder
package phy_mdio_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam logic [1:0] ST   = 2'b01;
    localparam logic [1:0] OP_R = 2'b10;
    localparam logic [1:0] OP_W = 2'b01;
    localparam logic [1:0] TA_W = 2'b10;
    typedef enum logic [2:0] {IDLE, ST1, OP, PHYAD, REGAD, TA, WDATA, RDATA} mdio_slv_state_t;
endpackage

// File: rtl/mdio_edge_sync.sv
// mdio_edge_sync: synchronizes mdc/mdio_i into clk and derives mdc rise/fall events
//   clk, rest_n       : system clock, async active-low reset
//   mdc, mdio_i       : asynchronous management clock and data pin
//   mdc_rise/mdc_fall : one-clk event pulses of the synced mdc
//   mdio_s            : synced mdio_i, aligned with the synced mdc
module mdio_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rest_n,
    input  logic mdc,
    input  logic mdio_i,
    output logic mdc_rise,
    output logic mdc_fall,
    output logic mdio_s
);
    logic [SYNC_STAGES-1:0] mdc_q, mdio_q;
    logic                   mdc_prev_q;

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            mdc_q      <= '0;
            mdio_q     <= '0;
            mdc_prev_q <= 1'b0;
        end else begin
            mdc_q      <= {mdc_q[SYNC_STAGES-2:0], mdc};
            mdio_q     <= {mdio_q[SYNC_STAGES-2:0], mdio_i};
            mdc_prev_q <= mdc_q[SYNC_STAGES-1];
        end
    end

    assign mdc_rise = mdc_q[SYNC_STAGES-1] & ~mdc_prev_q;
    assign mdc_fall = ~mdc_q[SYNC_STAGES-1] & mdc_prev_q;
    assign mdio_s   = mdio_q[SYNC_STAGES-1];
endmodule

// File: rtl/phy_mdio_slave.sv
// phy_mdio_slave: clause-22 MDIO responder issuing register read/write requests
//   clk, rest_n        : system clock (>= 8x mdc), async active-low reset
//   phy_addr           : this responder's PHY address
//   mdc, mdio_i        : management clock and data in from the master
//   mdio_o, mdio_oe    : data drive value and enable for the pad tristate
//   rd_req, wr_req     : one-clk register request pulses
//   reg_addr, wr_data  : request address and write data, held after the pulse
//   rd_data            : read data, sampled two clk after rd_req
//   busy, frame_err    : frame in progress, malformed-frame pulse
module phy_mdio_slave
    import phy_mdio_pkg::*;
#(
    parameter int PREAMBLE_MIN = 32,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rest_n,
    input  logic [ADDR_W-1:0] phy_addr,
    input  logic              mdc,
    input  logic              mdio_i,
    output logic              mdio_o,
    output logic              mdio_oe,
    output logic              rd_req,
    output logic              wr_req,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              frame_err
);
    localparam logic [5:0] PMIN = 6'(PREAMBLE_MIN);

    logic rise, fall, sdi, rd, op_ok;
    mdio_slv_state_t   state_q, state_d;
    logic [5:0]        pre_q, pre_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic              ta_q, ta_d, ta_ok_q, ta_ok_d, match_q, match_d;
    logic [ADDR_W-1:0] adr_q, adr_d, reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] sh_q, sh_d, wr_data_q, wr_data_d;
    logic              o_q, o_d, oe_q, oe_d, rd_req_q, rd_req_d, wr_req_q, wr_req_d;
    logic              err_q, err_d, rd_dly_q;

    mdio_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rest_n(rest_n), .mdc(mdc), .mdio_i(mdio_i),
        .mdc_rise(rise), .mdc_fall(fall), .mdio_s(sdi)
    );

    assign rd    = (op_q == OP_R);
    assign op_ok = ({op_q[0], sdi} == OP_R) || ({op_q[0], sdi} == OP_W);

    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        ta_d       = ta_q;
        ta_ok_d    = ta_ok_q;
        match_d    = match_q;
        adr_d      = adr_q;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        o_d        = o_q;
        oe_d       = oe_q;
        rd_req_d   = 1'b0;
        wr_req_d   = 1'b0;
        err_d      = 1'b0;
        // Read data is captured two clk after the rd_req pulse; the shift register is idle then.
        sh_d       = rd_dly_q ? rd_data : sh_q;
        case (state_q)
            IDLE: if (rise) begin
                pre_d   = sdi ? ((pre_q == PMIN) ? pre_q : pre_q + 6'd1) : 6'd0;
                state_d = (!sdi && pre_q == PMIN) ? ST1 : IDLE;
            end
            ST1: if (rise) begin
                cnt_d   = '0;
                state_d = ({1'b0, sdi} == ST) ? OP : IDLE;
                err_d   = !sdi;
            end
            OP: if (rise) begin
                op_d    = {op_q[0], sdi};
                cnt_d   = cnt_q[0] ? 5'd0 : 5'd1;
                state_d = !cnt_q[0] ? OP : (op_ok ? PHYAD : IDLE);
                err_d   = cnt_q[0] && !op_ok;
            end
            PHYAD: if (rise) begin
                adr_d   = {adr_q[3:0], sdi};
                match_d = ({adr_q[3:0], sdi} == phy_addr);
                cnt_d   = (cnt_q == 5'd4) ? 5'd0 : cnt_q + 5'd1;
                state_d = (cnt_q == 5'd4) ? REGAD : PHYAD;
            end
            REGAD: if (rise) begin
                adr_d = {adr_q[3:0], sdi};
                cnt_d = (cnt_q == 5'd4) ? 5'd0 : cnt_q + 5'd1;
                if (cnt_q == 5'd4) begin
                    state_d = TA;
                    if (rd && match_q) begin
                        rd_req_d   = 1'b1;
                        reg_addr_d = {adr_q[3:0], sdi};
                    end
                end
            end
            TA: begin
                // First TA fall stays released; the second drives the turnaround zero.
                if (fall && rd && match_q && cnt_q == 5'd1) begin
                    oe_d = 1'b1;
                    o_d  = 1'b0;
                end
                if (rise) begin
                    ta_d    = sdi;
                    ta_ok_d = ({ta_q, sdi} == TA_W);
                    cnt_d   = (cnt_q == 5'd1) ? 5'd0 : 5'd1;
                    state_d = (cnt_q != 5'd1) ? TA : (rd ? RDATA : WDATA);
                end
            end
            WDATA: if (rise) begin
                sh_d  = {sh_q[DATA_W-2:0], sdi};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (match_q && ta_ok_q) begin
                        wr_req_d   = 1'b1;
                        wr_data_d  = {sh_q[DATA_W-2:0], sdi};
                        reg_addr_d = adr_q;
                    end
                    err_d = match_q && !ta_ok_q;
                end
            end
            RDATA: if (fall) begin
                // Falls 0..15 drive bits 15..0; fall 16 ends the bit-0 period.
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd16) begin
                    cnt_d   = '0;
                    oe_d    = 1'b0;
                    o_d     = 1'b0;
                    state_d = IDLE;
                end else if (match_q) begin
                    oe_d = 1'b1;
                    o_d  = sh_q[DATA_W-1];
                    sh_d = {sh_q[DATA_W-2:0], 1'b0};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
            ta_q       <= 1'b0;
            ta_ok_q    <= 1'b0;
            match_q    <= 1'b0;
            adr_q      <= '0;
            reg_addr_q <= '0;
            sh_q       <= '0;
            wr_data_q  <= '0;
            o_q        <= 1'b0;
            oe_q       <= 1'b0;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            err_q      <= 1'b0;
            rd_dly_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            ta_q       <= ta_d;
            ta_ok_q    <= ta_ok_d;
            match_q    <= match_d;
            adr_q      <= adr_d;
            reg_addr_q <= reg_addr_d;
            sh_q       <= sh_d;
            wr_data_q  <= wr_data_d;
            o_q        <= o_d;
            oe_q       <= oe_d;
            rd_req_q   <= rd_req_d;
            wr_req_q   <= wr_req_d;
            err_q      <= err_d;
            rd_dly_q   <= rd_req_q;
        end
    end

    assign mdio_o    = o_q;
    assign mdio_oe   = oe_q;
    assign rd_req    = rd_req_q;
    assign wr_req    = wr_req_q;
    assign reg_addr  = reg_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = err_q;
    assign busy      = (state_q != IDLE);
endmodule
